// File: rtl/axi_rd_pkg.sv
// Shared encodings and state type for the AXI read burst scheduler.
// Imported by the scheduler top and its burst-length calculator.
package axi_rd_pkg;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam int         PAGE_BYTES  = 4096;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp != RESP_OKAY) && (resp != RESP_EXOKAY);
   endfunction

endpackage

// File: rtl/axi_rd_burst_calc.sv
// Burst length calculator: clips a request at MAX_BURST and the 4 KB page.
// Pure combinational; arlen_o is only meaningful while len_o != 0.
module axi_rd_burst_calc
   import axi_rd_pkg::*;
#(
   parameter int BPB       = 32,
   parameter int MAX_BURST = 16
) (
   input  logic [15:0] remaining_i,
   input  logic [11:0] page_off_i,
   output logic [8:0]  len_o,
   output logic [7:0]  arlen_o
);

   localparam int          SH   = $clog2(BPB);
   localparam logic [15:0] MAXB = 16'(MAX_BURST);

   logic [12:0] page_bytes;
   logic [15:0] page_beats;
   logic [15:0] lim;

   always_comb begin
      page_bytes = 13'(PAGE_BYTES) - {1'b0, page_off_i};
      page_beats = 16'(page_bytes >> SH);
      lim        = (remaining_i < MAXB) ? remaining_i : MAXB;
      if (page_beats < lim) lim = page_beats;
      len_o      = 9'(lim);
      arlen_o    = 8'(len_o - 9'd1);
   end

endmodule

// File: rtl/axi_rd_burst_sched.sv
// AXI4 read command scheduler: splits one linear descriptor into INCR
// bursts under a credit limit and forwards R beats to a stream.
module axi_rd_burst_sched
   import axi_rd_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 1,
   parameter int MAX_BURST  = 16,
   parameter int MAX_OUTST  = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_n_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [15:0]           cmd_beats_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [ID_WIDTH-1:0]   m_axi_arid_o,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr_o,
   output logic [7:0]            m_axi_arlen_o,
   output logic [2:0]            m_axi_arsize_o,
   output logic [1:0]            m_axi_arburst_o,
   output logic                  m_axi_arlock_o,
   output logic [3:0]            m_axi_arcache_o,
   output logic [2:0]            m_axi_arprot_o,
   output logic [3:0]            m_axi_arregion_o,
   output logic [3:0]            m_axi_arqos_o,
   output logic                  m_axi_aruser_o,
   output logic                  m_axi_arvalid_o,
   input  logic                  m_axi_arready_i,
   input  logic [ID_WIDTH-1:0]   m_axi_rid_i,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata_i,
   input  logic [1:0]            m_axi_rresp_i,
   input  logic                  m_axi_rlast_i,
   input  logic                  m_axi_ruser_i,
   input  logic                  m_axi_rvalid_i,
   output logic                  m_axi_rready_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic                  rd_last_o
);

   localparam int BPB = DATA_WIDTH / 8;
   localparam int SH  = $clog2(BPB);
   localparam int OW  = $clog2(MAX_OUTST + 1);
   localparam logic [OW-1:0]         OUTST_MAX = OW'(MAX_OUTST);
   localparam logic [ADDR_WIDTH-1:0] LSB_MASK  = ADDR_WIDTH'(BPB - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           rem_q, rem_d;
   logic [15:0]           rx_q, rx_d;
   logic [OW-1:0]         outst_q, outst_d;
   logic                  err_q, err_d;

   logic       cmd_hs, ar_hs, r_hs, rl_hs, rx_live;
   logic [8:0] blen;
   logic [7:0] calc_arlen;
   logic       unused_r;

   axi_rd_burst_calc #(
      .BPB       (BPB),
      .MAX_BURST (MAX_BURST)
   ) u_calc (
      .remaining_i (rem_q),
      .page_off_i  (addr_q[11:0]),
      .len_o       (blen),
      .arlen_o     (calc_arlen)
   );

   assign cmd_hs  = cmd_valid_i && cmd_ready_o;
   assign ar_hs   = m_axi_arvalid_o && m_axi_arready_i;
   assign r_hs    = m_axi_rvalid_i && m_axi_rready_o;
   assign rl_hs   = r_hs && m_axi_rlast_i && (outst_q != '0);
   assign rx_live = (rx_q != 16'd0);

   // Beats outside a command are swallowed so a stray response never stalls R.
   assign rd_data_o      = m_axi_rdata_i;
   assign rd_valid_o     = m_axi_rvalid_i && rx_live;
   assign rd_last_o      = m_axi_rvalid_i && (rx_q == 16'd1);
   assign m_axi_rready_o = rx_live ? rd_ready_i : 1'b1;

   assign m_axi_arid_o     = '0;
   assign m_axi_araddr_o   = addr_q;
   assign m_axi_arsize_o   = 3'(SH);
   assign m_axi_arburst_o  = BURST_INCR;
   assign m_axi_arlock_o   = 1'b0;
   assign m_axi_arcache_o  = 4'd0;
   assign m_axi_arprot_o   = 3'd0;
   assign m_axi_arregion_o = 4'd0;
   assign m_axi_arqos_o    = 4'd0;
   assign m_axi_aruser_o   = 1'b0;
   assign err_o            = err_q;
   assign unused_r         = ^{m_axi_rid_i, m_axi_ruser_i};

   always_comb begin
      addr_d  = addr_q;
      rem_d   = rem_q;
      rx_d    = rx_q;
      outst_d = outst_q;
      err_d   = err_q;
      if (ar_hs) begin
         addr_d = addr_q + (ADDR_WIDTH'(blen) << SH);
         rem_d  = rem_q - 16'(blen);
      end
      if (r_hs && rx_live) rx_d = rx_q - 16'd1;
      if (ar_hs && !rl_hs) outst_d = outst_q + 1'b1;
      if (!ar_hs && rl_hs) outst_d = outst_q - 1'b1;
      if (r_hs && resp_is_err(m_axi_rresp_i)) err_d = 1'b1;
      if (cmd_hs) begin
         addr_d = cmd_addr_i & ~LSB_MASK;
         rem_d  = cmd_beats_i;
         rx_d   = cmd_beats_i;
         err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         rx_q    <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         rx_q    <= rx_d;
         outst_q <= outst_d;
         err_q   <= err_d;
      end
   end

   // Drain exit looks at next-state counters so done follows the final rlast.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_hs)
               state_d = (cmd_beats_i == 16'd0) ? ST_DONE : ST_ISSUE;
         end
         ST_ISSUE: begin
            if (ar_hs && (rem_q == 16'(blen))) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if ((outst_d == '0) && (rx_d == 16'd0)) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready_o     = (state_q == ST_IDLE);
      busy_o          = (state_q != ST_IDLE);
      done_o          = (state_q == ST_DONE);
      m_axi_arvalid_o = 1'b0;
      m_axi_arlen_o   = 8'd0;
      if (state_q == ST_ISSUE) begin
         m_axi_arvalid_o = (outst_q < OUTST_MAX);
         m_axi_arlen_o   = calc_arlen;
      end
   end

endmodule

// File: tb/tb_axi_rd_burst_sched.sv
// Directed bench for axi_rd_burst_sched: AR log, scripted R slave,
// per-command deltas against hand-computed burst tables.
module tb_axi_rd_burst_sched;

   localparam int DW = 256;
   localparam int AW = 32;

   logic          clk_i = 1'b0;
   logic          reset_n_i = 1'b0;
   logic          cmd_valid_i, cmd_ready_o;
   logic [AW-1:0] cmd_addr_i;
   logic [15:0]   cmd_beats_i;
   logic          busy_o, done_o, err_o;
   logic [0:0]    arid;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize, arprot;
   logic [1:0]    arburst;
   logic          arlock, aruser, arvalid, arready;
   logic [3:0]    arcache, arregion, arqos;
   logic [0:0]    rid;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast, ruser, rvalid, rready;
   logic [DW-1:0] rd_data_o;
   logic          rd_valid_o, rd_ready_i, rd_last_o;

   always #5 clk_i = ~clk_i;

   axi_rd_burst_sched dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_addr_i(cmd_addr_i), .cmd_beats_i(cmd_beats_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .m_axi_arid_o(arid), .m_axi_araddr_o(araddr),
      .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize),
      .m_axi_arburst_o(arburst), .m_axi_arlock_o(arlock),
      .m_axi_arcache_o(arcache), .m_axi_arprot_o(arprot),
      .m_axi_arregion_o(arregion), .m_axi_arqos_o(arqos),
      .m_axi_aruser_o(aruser), .m_axi_arvalid_o(arvalid),
      .m_axi_arready_i(arready),
      .m_axi_rid_i(rid), .m_axi_rdata_i(rdata),
      .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
      .m_axi_ruser_i(ruser), .m_axi_rvalid_i(rvalid),
      .m_axi_rready_o(rready),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
      .rd_ready_i(rd_ready_i), .rd_last_o(rd_last_o)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [7:0]    l;
   } ar_t;

   ar_t ar_log[$];
   int  n_chk = 0, n_pass = 0;
   int  cyc = 0;
   int  fwd_cnt = 0, last_cnt = 0, last_at = 0, done_cnt = 0;
   int  last_rl_cyc = -1, done_cyc = -1, ar_rise_cyc = -1;
   int  err_rise_cyc = -1, err_hs_cyc = -1, cmd_cyc = -1;
   logic done_err = 1'b0;
   int  allow_lim = 1000000, err_at = 0;
   int  served = 0, rbeat = 0;
   int  b_ar, b_f, b_l;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   initial begin : mon
      logic prev_arv, prev_err;
      prev_arv = 1'b0;
      prev_err = 1'b0;
      forever begin
         @(negedge clk_i);
         if (arvalid && arready) ar_log.push_back('{araddr, arlen});
         if (arvalid && !prev_arv) ar_rise_cyc = cyc;
         prev_arv = arvalid;
         if (rvalid && rready) begin
            if (rlast) last_rl_cyc = cyc;
            if (rresp[1]) err_hs_cyc = cyc;
         end
         if (rd_valid_o && rd_ready_i) begin
            fwd_cnt++;
            if (rd_last_o) begin
               last_cnt++;
               last_at = fwd_cnt;
            end
         end
         if (err_o && !prev_err) err_rise_cyc = cyc;
         prev_err = err_o;
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err_o;
         end
      end
   end

   initial begin : slave
      int left;
      logic hs;
      left = 0;
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      rdata = '0; rid = '0; ruser = 1'b0;
      forever begin
         @(negedge clk_i);
         hs = rvalid && rready;
         @(posedge clk_i);
         #1;
         if (!reset_n_i) begin
            left = 0;
            served = ar_log.size();
         end else begin
            if (hs) begin
               rbeat++;
               left--;
            end
            if (left == 0 && served < ar_log.size() && served < allow_lim) begin
               left = int'(ar_log[served].l) + 1;
               served++;
            end
         end
         rvalid = (left != 0);
         rlast  = (left == 1);
         rdata  = DW'(rbeat);
         rresp  = (rbeat + 1 == err_at) ? 2'b10 : 2'b00;
      end
   end

   task automatic snap();
      b_ar = ar_log.size();
      b_f  = fwd_cnt;
      b_l  = last_cnt;
   endtask

   task automatic send_cmd(input logic [AW-1:0] a, input logic [15:0] n);
      int i;
      @(negedge clk_i);
      cmd_addr_i  = a;
      cmd_beats_i = n;
      cmd_valid_i = 1'b1;
      i = 0;
      while (!cmd_ready_o && i < 50) begin
         @(negedge clk_i);
         i++;
      end
      chk("cmd_ready_wait", 64'(cmd_ready_o), 64'd1);
      cmd_cyc = cyc;
      @(posedge clk_i);
      #1 cmd_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int d0, i;
      d0 = done_cnt;
      i = 0;
      while (done_cnt == d0 && i < lim) begin
         @(negedge clk_i);
         i++;
      end
      chk("done_seen", 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin : main
      int rl0, i;
      cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_beats_i = '0;
      arready = 1'b1; rd_ready_i = 1'b1;
      repeat (2) @(negedge clk_i);
      chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("rst_arvalid", 64'(arvalid), 64'd0);
      chk("rst_araddr", 64'(araddr), 64'd0);
      chk("rst_arlen", 64'(arlen), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_rready", 64'(rready), 64'd1);
      chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
      chk("rst_arsize", 64'(arsize), 64'd5);
      @(posedge clk_i);
      #1 reset_n_i = 1'b1;

      snap();
      send_cmd(32'h0, 16'd1);
      wait_done(100);
      chk("t1_ar_cnt", 64'(ar_log.size() - b_ar), 64'd1);
      chk("t1_addr", 64'(ar_log[b_ar].a), 64'h0);
      chk("t1_len", 64'(ar_log[b_ar].l), 64'd0);
      chk("t1_ar_lat", 64'(ar_rise_cyc), 64'(cmd_cyc + 1));
      chk("t1_last_at", 64'(last_at - b_f), 64'd1);
      chk("t1_done_lat", 64'(done_cyc), 64'(last_rl_cyc + 1));
      chk("t1_err", 64'(done_err), 64'd0);

      snap();
      send_cmd(32'h0, 16'd100);
      wait_done(1000);
      chk("t2_ar_cnt", 64'(ar_log.size() - b_ar), 64'd7);
      for (int k = 0; k < 7; k++) begin
         chk("t2_addr", 64'(ar_log[b_ar + k].a), 64'(k * 32'h200));
         chk("t2_len", 64'(ar_log[b_ar + k].l), (k == 6) ? 64'd3 : 64'd15);
      end
      chk("t2_fwd", 64'(fwd_cnt - b_f), 64'd100);
      chk("t2_last_cnt", 64'(last_cnt - b_l), 64'd1);
      chk("t2_last_at", 64'(last_at - b_f), 64'd100);
      chk("t2_done_lat", 64'(done_cyc), 64'(last_rl_cyc + 1));

      snap();
      send_cmd(32'hFE0, 16'd3);
      wait_done(200);
      chk("t3_ar_cnt", 64'(ar_log.size() - b_ar), 64'd2);
      chk("t3_addr0", 64'(ar_log[b_ar].a), 64'hFE0);
      chk("t3_len0", 64'(ar_log[b_ar].l), 64'd0);
      chk("t3_addr1", 64'(ar_log[b_ar + 1].a), 64'h1000);
      chk("t3_len1", 64'(ar_log[b_ar + 1].l), 64'd1);
      chk("t3_fwd", 64'(fwd_cnt - b_f), 64'd3);

      snap();
      allow_lim = ar_log.size();
      send_cmd(32'h0, 16'd100);
      repeat (20) @(negedge clk_i);
      chk("t4_stall_cnt", 64'(ar_log.size() - b_ar), 64'd4);
      chk("t4_stall_arv", 64'(arvalid), 64'd0);
      chk("t4_busy", 64'(busy_o), 64'd1);
      rl0 = last_rl_cyc;
      allow_lim = b_ar + 1;
      i = 0;
      while (last_rl_cyc == rl0 && i < 60) begin
         @(negedge clk_i);
         i++;
      end
      repeat (5) @(negedge clk_i);
      chk("t4_one_more", 64'(ar_log.size() - b_ar), 64'd5);
      chk("t4_addr4", 64'(ar_log[b_ar + 4].a), 64'h800);
      chk("t4_rise_lat", 64'(ar_rise_cyc), 64'(last_rl_cyc + 1));
      chk("t4_restall", 64'(arvalid), 64'd0);
      allow_lim = 1000000;
      wait_done(1000);
      chk("t4_fwd", 64'(fwd_cnt - b_f), 64'd100);
      chk("t4_last_at", 64'(last_at - b_f), 64'd100);

      err_at = rbeat + 2;
      send_cmd(32'h40, 16'd4);
      wait_done(200);
      chk("t5_err_lat", 64'(err_rise_cyc), 64'(err_hs_cyc + 1));
      chk("t5_err_done", 64'(done_err), 64'd1);
      @(negedge clk_i);
      chk("t5_err_sticky", 64'(err_o), 64'd1);
      err_at = 0;
      send_cmd(32'h0, 16'd1);
      @(negedge clk_i);
      chk("t5_err_clr", 64'(err_o), 64'd0);
      wait_done(100);
      chk("t5_err_done2", 64'(done_err), 64'd0);

      snap();
      send_cmd(32'h100, 16'd0);
      wait_done(10);
      chk("t6_done_lat", 64'(done_cyc), 64'(cmd_cyc + 1));
      chk("t6_no_ar", 64'(ar_log.size() - b_ar), 64'd0);
      chk("t6_no_beats", 64'(fwd_cnt - b_f), 64'd0);

      snap();
      allow_lim = ar_log.size();
      send_cmd(32'h2000, 16'd8);
      repeat (5) @(negedge clk_i);
      chk("t7_ar_cnt", 64'(ar_log.size() - b_ar), 64'd1);
      chk("t7_busy", 64'(busy_o), 64'd1);
      @(posedge clk_i);
      #1 reset_n_i = 1'b0;
      @(negedge clk_i);
      chk("t7_rst_busy", 64'(busy_o), 64'd0);
      chk("t7_rst_ready", 64'(cmd_ready_o), 64'd1);
      chk("t7_rst_arvalid", 64'(arvalid), 64'd0);
      chk("t7_rst_araddr", 64'(araddr), 64'd0);
      chk("t7_rst_rd_valid", 64'(rd_valid_o), 64'd0);
      repeat (2) @(posedge clk_i);
      allow_lim = 1000000;
      #1 reset_n_i = 1'b1;
      snap();
      send_cmd(32'h40, 16'd2);
      wait_done(100);
      chk("t7_ar_cnt2", 64'(ar_log.size() - b_ar), 64'd1);
      chk("t7_addr2", 64'(ar_log[b_ar].a), 64'h40);
      chk("t7_len2", 64'(ar_log[b_ar].l), 64'd1);
      chk("t7_last_at", 64'(last_at - b_f), 64'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
